// File: rtl/interrupt_controller_pkg.sv
// Shared definitions for the interrupt controller, the control unit and the program ROM.
// Holds the tracker state encoding and the fetch-state / return-instruction defaults.
package interrupt_controller_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    WAIT_CLR = 2'b01,
    PEND     = 2'b10,
    SERVICE  = 2'b11
  } ic_state_e;

  localparam int unsigned FETCH_STATE_DEF   = 0;
  localparam int unsigned MI_RET_INSTR_DEF  = 0;
  localparam int unsigned NMI_RET_INSTR_DEF = 100;

endpackage

// File: rtl/interrupt_controller_prio.sv
// Combinational priority encoder: reports the lowest set index of req_i and whether any bit is set.
module prio_encoder_lsb #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] req_i,
  output logic [W-1:0] idx_o,
  output logic         valid_o
);

  // Scanning from the top down lets the lowest set bit overwrite all higher ones.
  always_comb begin
    idx_o   = '0;
    valid_o = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        idx_o   = W'(i);
        valid_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/interrupt_controller.sv
// Multi-source interrupt tracker: arbitrates maskable requests plus an NMI, redirects the PC
// at a fetch boundary, follows the handler to its return instruction and acknowledges the source.
module interrupt_controller
  import interrupt_controller_pkg::*;
#(
  parameter int          NUM_SRC       = 4,
  parameter int          VEC_W         = 2,
  parameter int          INSTR_W       = 32,
  parameter int          CTRL_W        = 4,
  parameter int unsigned FETCH_STATE   = FETCH_STATE_DEF,
  parameter int unsigned MI_RET_INSTR  = MI_RET_INSTR_DEF,
  parameter int unsigned NMI_RET_INSTR = NMI_RET_INSTR_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [CTRL_W-1:0]  control_state,
  input  logic [INSTR_W-1:0] instr,
  input  logic [NUM_SRC-1:0] irq,
  input  logic [NUM_SRC-1:0] irq_mask,
  input  logic               busy,
  input  logic               nmi,
  output logic               respond,
  output logic               nmi_active,
  output logic [VEC_W-1:0]   vector,
  output logic [NUM_SRC-1:0] ack,
  output logic               nmi_ack,
  output logic [1:0]         state
);

  ic_state_e          state_q;
  logic               respond_q;
  logic               nmiActive_q;
  logic [VEC_W-1:0]   vector_q;
  logic [NUM_SRC-1:0] ack_q;
  logic               nmiAck_q;

  logic [NUM_SRC-1:0] elig;
  logic [NUM_SRC-1:0] selMask;
  logic [VEC_W-1:0]   winIdx;
  logic               winValid;
  logic               atFetch;
  logic               retHit;
  logic               nmiEff;
  logic               withdrawn;
  logic               lineLow;

  assign elig    = irq & irq_mask & {NUM_SRC{~busy}};
  assign selMask = NUM_SRC'(1) << vector_q;
  assign atFetch = (control_state == CTRL_W'(FETCH_STATE));
  assign retHit  = nmiActive_q ? (instr == INSTR_W'(NMI_RET_INSTR))
                               : (instr == INSTR_W'(MI_RET_INSTR));
  // An NMI arriving while still pending pins the request, so it can no longer be withdrawn.
  assign nmiEff    = nmiActive_q | nmi;
  assign withdrawn = ~|(elig & selMask);
  assign lineLow   = nmiActive_q ? ~nmi : ~|(irq & selMask);

  prio_encoder_lsb #(
    .N(NUM_SRC),
    .W(VEC_W)
  ) u_prio (
    .req_i  (elig),
    .idx_o  (winIdx),
    .valid_o(winValid)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      respond_q   <= 1'b0;
      nmiActive_q <= 1'b0;
      vector_q    <= '0;
      ack_q       <= '0;
      nmiAck_q    <= 1'b0;
    end else begin
      respond_q <= 1'b0;
      ack_q     <= '0;
      nmiAck_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (nmi) begin
            state_q     <= PEND;
            nmiActive_q <= 1'b1;
            vector_q    <= '0;
          end else if (winValid) begin
            state_q     <= PEND;
            nmiActive_q <= 1'b0;
            vector_q    <= winIdx;
          end
        end
        PEND: begin
          if (nmi && !nmiActive_q) begin
            nmiActive_q <= 1'b1;
            vector_q    <= '0;
          end
          if (!nmiEff && withdrawn) begin
            state_q <= IDLE;
          end else if (atFetch) begin
            state_q   <= SERVICE;
            respond_q <= 1'b1;
          end
        end
        SERVICE: begin
          if (atFetch && retHit) begin
            state_q <= WAIT_CLR;
            if (nmiActive_q) nmiAck_q <= 1'b1;
            else             ack_q    <= selMask;
          end
        end
        WAIT_CLR: begin
          if (lineLow) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign respond    = respond_q;
  assign nmi_active = nmiActive_q;
  assign vector     = vector_q;
  assign ack        = ack_q;
  assign nmi_ack    = nmiAck_q;
  assign state      = state_q;

endmodule

// File: tb/tb_interrupt_controller.sv
// Scoreboard bench for interrupt_controller: a behavioural model predicts respond/ack pulses,
// a monitor compares them (and the debug state) against the DUT at each falling edge.
module tb_interrupt_controller;

  localparam int NUM_SRC = 4;
  localparam int VEC_W   = 2;
  localparam int INSTR_W = 32;
  localparam int CTRL_W  = 4;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic [CTRL_W-1:0]  control_state;
  logic [INSTR_W-1:0] instr;
  logic [NUM_SRC-1:0] irq;
  logic [NUM_SRC-1:0] irq_mask;
  logic               busy;
  logic               nmi;
  logic               respond;
  logic               nmi_active;
  logic [VEC_W-1:0]   vector;
  logic [NUM_SRC-1:0] ack;
  logic               nmi_ack;
  logic [1:0]         state;

  int testsRun    = 0;
  int testsFailed = 0;

  typedef struct {
    bit isRespond;
    bit isNmi;
    int src;
  } expEvent_t;

  expEvent_t  expQ[$];
  int         stage = 0;
  bit         mIsNmi = 1'b0;
  int         mOwner = 0;
  logic [1:0] expState = 2'b00;

  interrupt_controller #(
    .NUM_SRC(NUM_SRC),
    .VEC_W  (VEC_W),
    .INSTR_W(INSTR_W),
    .CTRL_W (CTRL_W)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .control_state(control_state),
    .instr        (instr),
    .irq          (irq),
    .irq_mask     (irq_mask),
    .busy         (busy),
    .nmi          (nmi),
    .respond      (respond),
    .nmi_active   (nmi_active),
    .vector       (vector),
    .ack          (ack),
    .nmi_ack      (nmi_ack),
    .state        (state)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic [NUM_SRC-1:0] irqV, input logic [NUM_SRC-1:0] maskV,
                               input logic busyV, input logic nmiV,
                               input logic [CTRL_W-1:0] csV, input logic [INSTR_W-1:0] instrV);
    irq           = irqV;
    irq_mask      = maskV;
    busy          = busyV;
    nmi           = nmiV;
    control_state = csV;
    instr         = instrV;
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic int lowestSet(input logic [NUM_SRC-1:0] v);
    for (int i = 0; i < NUM_SRC; i++) if (v[i]) return i;
    return -1;
  endfunction

  // Reference model: stage 0 = no request, 1 = accepted and waiting for a fetch boundary,
  // 2 = handler running, 3 = acknowledged and waiting for the line to drop.
  always @(posedge clk or posedge reset) begin
    logic [NUM_SRC-1:0] el;
    bit fetch;
    if (reset) begin
      stage  = 0;
      mIsNmi = 1'b0;
      mOwner = 0;
      expQ.delete();
    end else begin
      el    = irq & irq_mask & {NUM_SRC{~busy}};
      fetch = (control_state == 0);
      if (stage == 0) begin
        if (nmi) begin
          stage = 1; mIsNmi = 1'b1; mOwner = 0;
        end else if (el != 0) begin
          stage = 1; mIsNmi = 1'b0; mOwner = lowestSet(el);
        end
      end else if (stage == 1) begin
        if (nmi && !mIsNmi) begin
          mIsNmi = 1'b1; mOwner = 0;
        end
        if (!mIsNmi && !el[mOwner]) stage = 0;
        else if (fetch) begin
          stage = 2;
          expQ.push_back('{isRespond: 1'b1, isNmi: mIsNmi, src: mOwner});
        end
      end else if (stage == 2) begin
        if (fetch && instr == (mIsNmi ? 100 : 0)) begin
          stage = 3;
          expQ.push_back('{isRespond: 1'b0, isNmi: mIsNmi, src: mOwner});
        end
      end else begin
        if (mIsNmi ? !nmi : !irq[mOwner]) stage = 0;
      end
    end
    case (stage)
      0:       expState = 2'b00;
      1:       expState = 2'b10;
      2:       expState = 2'b11;
      default: expState = 2'b01;
    endcase
  end

  // Monitor: every DUT pulse must match the oldest predicted event, and vice versa.
  always @(negedge clk) begin
    expEvent_t e;
    logic pulse;
    if (!reset) begin
      checkOutput("state", 32'(state), 32'(expState));
      pulse = respond | nmi_ack | (|ack);
      if (pulse || expQ.size() > 0) begin
        if (expQ.size() == 0) begin
          checkOutput("unexpected pulse {respond,nmi_ack,ack}", {26'd0, respond, nmi_ack, ack}, 32'd0);
        end else begin
          e = expQ.pop_front();
          if (e.isRespond) begin
            checkOutput("respond", 32'(respond), 32'd1);
            checkOutput("respond nmi_active", 32'(nmi_active), 32'(e.isNmi));
            checkOutput("respond vector", 32'(vector), 32'(e.src));
            checkOutput("respond ack quiet", {27'd0, nmi_ack, ack}, 32'd0);
          end else begin
            checkOutput("completion respond quiet", 32'(respond), 32'd0);
            checkOutput("nmi_ack", 32'(nmi_ack), 32'(e.isNmi));
            checkOutput("ack", 32'(ack), e.isNmi ? 32'd0 : (32'd1 << e.src));
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    testsFailed++;
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    applyStimulus(4'b0000, 4'hF, 1'b0, 1'b0, 4'd3, 32'd7);
    #2;
    checkOutput("reset state", 32'(state), 32'd0);
    checkOutput("reset respond", 32'(respond), 32'd0);
    checkOutput("reset nmi_active", 32'(nmi_active), 32'd0);
    checkOutput("reset vector", 32'(vector), 32'd0);
    checkOutput("reset acks", {27'd0, nmi_ack, ack}, 32'd0);
    step(2);
    reset = 1'b0;

    // Single source
    applyStimulus(4'b0100, 4'hF, 1'b0, 1'b0, 4'd3, 32'd7);
    step(3);
    checkOutput("t1 pending", 32'(state), 32'b10);
    control_state = 4'd0;
    step(1);
    checkOutput("t1 respond", 32'(respond), 32'd1);
    checkOutput("t1 vector", 32'(vector), 32'd2);
    step(1);
    checkOutput("t1 single respond", 32'(respond), 32'd0);
    instr = 32'd0;
    step(1);
    checkOutput("t1 ack", 32'(ack), 32'b0100);
    step(1);
    checkOutput("t1 ack one cycle", 32'(ack), 32'd0);
    checkOutput("t1 wait clear", 32'(state), 32'b01);
    irq = 4'b0000;
    step(1);
    checkOutput("t1 idle", 32'(state), 32'd0);

    // Priority and mask
    applyStimulus(4'b1010, 4'b1000, 1'b0, 1'b0, 4'd3, 32'd7);
    step(1);
    checkOutput("t2 masked vector", 32'(vector), 32'd3);
    control_state = 4'd0; step(1);
    instr = 32'd0; step(1);
    applyStimulus(4'b0000, 4'hF, 1'b0, 1'b0, 4'd3, 32'd7); step(1);
    applyStimulus(4'b1010, 4'hF, 1'b0, 1'b0, 4'd3, 32'd7);
    step(1);
    checkOutput("t2 priority vector", 32'(vector), 32'd1);
    control_state = 4'd0; step(1);
    instr = 32'd0; step(1);
    applyStimulus(4'b0000, 4'hF, 1'b0, 1'b0, 4'd3, 32'd7); step(1);
    applyStimulus(4'b1010, 4'hF, 1'b1, 1'b0, 4'd3, 32'd7);
    step(3);
    checkOutput("t2 busy blocks", 32'(state), 32'd0);
    applyStimulus(4'b0000, 4'hF, 1'b0, 1'b0, 4'd3, 32'd7); step(1);

    // NMI beats a simultaneous maskable request, then an upgrade while pending
    applyStimulus(4'b0001, 4'hF, 1'b0, 1'b1, 4'd3, 32'd7);
    step(1);
    checkOutput("t3 nmi wins", 32'(nmi_active), 32'd1);
    control_state = 4'd0; step(1);
    instr = 32'd0; irq = 4'b0000; step(2);
    checkOutput("t3 mi ret ignored", 32'(state), 32'b11);
    instr = 32'd100; step(1);
    checkOutput("t3 nmi_ack", 32'(nmi_ack), 32'd1);
    applyStimulus(4'b0000, 4'hF, 1'b0, 1'b0, 4'd3, 32'd7); step(1);
    applyStimulus(4'b0001, 4'hF, 1'b0, 1'b0, 4'd5, 32'd7);
    step(1);
    checkOutput("t3 maskable first", 32'(nmi_active), 32'd0);
    nmi = 1'b1; step(1);
    checkOutput("t3 upgrade", 32'(nmi_active), 32'd1);
    control_state = 4'd0; step(1);
    instr = 32'd0; step(1);
    instr = 32'd100; step(1);
    applyStimulus(4'b0000, 4'hF, 1'b0, 1'b0, 4'd3, 32'd7); step(1);

    // Withdrawal before fetch
    applyStimulus(4'b0010, 4'hF, 1'b0, 1'b0, 4'd5, 32'd7);
    step(1);
    irq_mask = 4'b1101; step(1);
    checkOutput("t4 withdrawn", 32'(state), 32'd0);
    control_state = 4'd0; step(2);
    applyStimulus(4'b0000, 4'hF, 1'b0, 1'b0, 4'd3, 32'd7); step(1);

    // No re-respond or preemption inside a handler
    applyStimulus(4'b0001, 4'hF, 1'b0, 1'b0, 4'd3, 32'd7); step(1);
    control_state = 4'd0; step(1);
    instr = 32'd5; nmi = 1'b1; step(1);
    nmi = 1'b0; step(1);
    nmi = 1'b1; step(2);
    checkOutput("t5 no re-respond", 32'(respond), 32'd0);
    checkOutput("t5 no preempt", 32'(state), 32'b11);
    instr = 32'd0; step(1);
    irq = 4'b0000; instr = 32'd5; step(3);
    checkOutput("t5 nmi after clear", 32'(respond & nmi_active), 32'd1);
    instr = 32'd100; step(1);
    applyStimulus(4'b0000, 4'hF, 1'b0, 1'b0, 4'd3, 32'd7); step(1);

    // Async reset mid-handler
    applyStimulus(4'b1000, 4'hF, 1'b0, 1'b0, 4'd3, 32'd7); step(1);
    control_state = 4'd0; step(1);
    #2 reset = 1'b1;
    #1;
    checkOutput("t6 async state", 32'(state), 32'd0);
    checkOutput("t6 async vector", 32'(vector), 32'd0);
    checkOutput("t6 async outputs", {26'd0, respond, nmi_ack, ack}, 32'd0);
    irq = 4'b0000; instr = 32'd0;
    @(posedge clk);
    #4 reset = 1'b0;
    step(4);
    checkOutput("t6 stays idle", 32'(state), 32'd0);

    // Randomised phase
    for (int c = 0; c < 1500; c++) begin
      for (int b = 0; b < NUM_SRC; b++) if ($urandom_range(0, 9) == 0) irq[b] = ~irq[b];
      irq_mask = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'hF;
      busy     = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 14) == 0) nmi = ~nmi;
      control_state = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
      case ($urandom_range(0, 4))
        0, 1:    instr = 32'd0;
        2:       instr = 32'd100;
        default: instr = $urandom;
      endcase
      step(1);
    end
    applyStimulus(4'b0000, 4'hF, 1'b0, 1'b0, 4'd3, 32'd7);
    step(3);
    checkOutput("scoreboard drained", 32'(expQ.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/interrupt_controller.md
Name: interrupt_controller

Overview:
- Parametrised successor to the single-source interrupt state tracker.
- Arbitrates NUM_SRC level-sensitive maskable requests plus one non-maskable request; lowest index wins among maskable sources.
- Raises a one-cycle respond to the multi-cycle control unit at an instruction-fetch boundary, tracks the handler until its return instruction, acknowledges the source, then waits for deassertion.
- Sits between the peripheral request lines and the control unit's PC-redirect logic.

Parameters:
- NUM_SRC, 4: number of maskable request lines (1..16).
- VEC_W, 2: vector width; 2**VEC_W >= NUM_SRC.
- INSTR_W, 32: instruction width.
- CTRL_W, 4: control-unit state width.
- FETCH_STATE, 0: control_state value marking an instruction-fetch boundary.
- MI_RET_INSTR, 0: last instruction of a maskable handler.
- NMI_RET_INSTR, 100: last instruction of the NMI handler.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high.
- control_state  in  CTRL_W  current control-unit state.
- instr  in  INSTR_W  instruction register contents.
- irq  in  NUM_SRC  maskable requests; level, held until acknowledged.
- irq_mask  in  NUM_SRC  per-source enable; 1 = enabled.
- busy  in  1  global maskable suppression; 1 blocks all of irq.
- nmi  in  1  non-maskable request; level.
- respond  out  1  one-cycle pulse: redirect PC to handler.
- nmi_active  out  1  accepted request is the NMI.
- vector  out  VEC_W  index of the accepted maskable source; 0 for NMI.
- ack  out  NUM_SRC  one-hot one-cycle completion pulse for a maskable source.
- nmi_ack  out  1  one-cycle completion pulse for the NMI.
- state  out  2  FSM state, for debug.

Behaviour:
- Reset (async, immediate): state=IDLE; respond, nmi_active, vector, ack and nmi_ack all 0. Reset mid-handler abandons it; no ack is issued.
- Eligibility: elig = irq & irq_mask & {NUM_SRC{~busy}}.
- All outputs are registered and updated on posedge clk. ack, nmi_ack and respond default to 0 every cycle.
- IDLE (2'b00):
  - nmi=1 → PEND, nmi_active=1, vector=0. NMI beats simultaneous maskable requests.
  - else |elig → PEND, nmi_active=0, vector=lowest set index of elig.
  - else remain in IDLE.
- PEND (2'b10):
  - If nmi=1 and nmi_active=0, upgrade: nmi_active=1, vector=0. This is allowed only before respond.
  - If the latched maskable source has left elig (masked or busy) and nmi_active=0 → IDLE, no respond.
  - Else if control_state==FETCH_STATE → SERVICE with respond=1 for exactly that next cycle.
  - Latency: request seen at edge N; earliest respond is high in cycle N+1→N+2, when the fetch state is already present.
- SERVICE (2'b11):
  - No preemption. A new nmi during a maskable handler is held until IDLE.
  - Completes when control_state==FETCH_STATE and instr equals NMI_RET_INSTR (nmi_active=1) or MI_RET_INSTR (nmi_active=0).
  - On completion: → WAIT_CLR with one cycle of nmi_ack, or ack[vector]=1.
  - respond is never re-asserted in SERVICE.
- WAIT_CLR (2'b01): → IDLE once the latched line is low (nmi for NMI, irq[vector] for maskable). Other lines are ignored; they are re-arbitrated in IDLE.
- Back-to-back requests: minimum one IDLE cycle between WAIT_CLR exit and the next PEND.
- Width rules:
  - vector is zero-extended when NUM_SRC < 2**VEC_W.
  - The instr comparison is full INSTR_W equality.
  - Indices >= NUM_SRC are never produced.

Decomposition:
- Shared package holds:
  - state encodings IDLE/PEND/SERVICE/WAIT_CLR;
  - FETCH_STATE, MI_RET_INSTR and NMI_RET_INSTR defaults, also used by the control unit and program ROM.
- One sub-module: prio_encoder_lsb (parameter N), combinational. Outputs the lowest set index and a valid bit.

Test Plan:
- Single source: reset; irq=4'b0100, mask=4'hF, busy=0; control_state=0 after 3 cycles → vector=2, one respond pulse; instr=0 at fetch → ack=4'b0100 for one cycle; drop irq[2] → state=00.
- Priority and mask: irq=4'b1010 with mask=4'b1000 → vector=3. With mask=4'hF → vector=1. With busy=1 → state stays 00.
- NMI wins and upgrades: nmi and irq[0] rise together → nmi_active=1. Maskable in PEND with control_state=5, then nmi → nmi_active=1 before respond; completes only on instr=100 → nmi_ack.
- Withdrawal: irq[1] pending in PEND, mask bit cleared before fetch → back to IDLE, respond never asserted.
- No re-respond or preemption: in SERVICE, several fetch cycles with instr≠0 and nmi pulsed → respond stays 0; NMI is serviced only after WAIT_CLR→IDLE.
- Async reset mid-SERVICE: assert reset between edges → state=00 and all outputs 0 immediately; no ack afterwards.
